// File: rtl/datapath_gearbox_fifo.sv
// Width-converting FIFO: packs BEATS narrow beats into one wide word, stores DEPTH words and
// releases them at a runtime-programmable read pace with sticky error reporting.
module datapath_gearbox_fifo #(
    parameter int unsigned IN_WIDTH  = 128,
    parameter int unsigned OUT_WIDTH = 192,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DIV_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 rd,
    input  logic [DIV_W-1:0]     rd_div,
    input  logic [ADDR_W:0]      thresh,
    input  logic                 flush,
    input  logic                 clr_err,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 rd_valid,
    output logic [ADDR_W:0]      data_count,
    output logic                 full,
    output logic                 empty,
    output logic                 threshold,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int unsigned BEATS  = (OUT_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int unsigned LAST_W = OUT_WIDTH - IN_WIDTH * (BEATS - 1);
    localparam int unsigned PACK_W = IN_WIDTH * (BEATS - 1);
    localparam int unsigned BIDX_W = $clog2(BEATS);
    localparam logic [BIDX_W-1:0] LastBeat = BIDX_W'(BEATS - 1);

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [PACK_W-1:0]    pack_q;
    logic [BIDX_W-1:0]    beat_q, beat_d;
    logic [ADDR_W:0]      wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [OUT_WIDTH-1:0] data_out_q;
    logic                 rd_valid_q, overflow_q, overflow_d, underflow_q, underflow_d;
    logic                 slot, last_beat, pop_req, commit_ok, pop, commit;
    logic [OUT_WIDTH-1:0] word;

    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign threshold = (count_q >= thresh);

    assign slot      = (div_q == rd_div);
    assign last_beat = wr && (beat_q == LastBeat);
    assign pop_req   = rd && slot && !empty;
    // A pop in the same cycle frees the slot the final beat needs.
    assign commit_ok = !full || pop_req;
    assign pop       = pop_req && !flush;
    assign commit    = last_beat && commit_ok && !flush;
    assign word      = {data_in[LAST_W-1:0], pack_q};

    always_comb begin
        div_d = (slot || (div_q > rd_div)) ? '0 : div_q + DIV_W'(1);

        beat_d = beat_q;
        if (wr) beat_d = (beat_q == LastBeat) ? '0 : beat_q + BIDX_W'(1);

        wptr_d  = wptr_q + (ADDR_W+1)'(commit);
        rptr_d  = rptr_q + (ADDR_W+1)'(pop);
        count_d = count_q;
        unique case ({commit, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            beat_d  = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end

        // New events win over a simultaneous clear.
        overflow_d  = (last_beat && !commit_ok) || (overflow_q && !clr_err);
        underflow_d = (rd && slot && empty) || (underflow_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            div_q       <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            div_q       <= div_d;
            rd_valid_q  <= pop;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (pop) data_out_q <= mem[rptr_q[ADDR_W-1:0]];
        end
    end

    // Storage and partial-word holding need no reset; beat_q gates their use.
    always_ff @(posedge clk) begin
        if (commit) mem[wptr_q[ADDR_W-1:0]] <= word;
        if (wr && !last_beat) begin
            for (int k = 0; k < int'(BEATS) - 1; k++) begin
                if (beat_q == BIDX_W'(k)) pack_q[IN_WIDTH*k +: IN_WIDTH] <= data_in;
            end
        end
    end

    assign data_out   = data_out_q;
    assign rd_valid   = rd_valid_q;
    assign data_count = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
endmodule

// File: tb/tb_datapath_gearbox_fifo.sv
// Randomised and directed bench for datapath_gearbox_fifo with a queue-based reference model
// and a scoreboard monitor that checks every popped word and status output.
module tb_datapath_gearbox_fifo;
    localparam int IW = 128;
    localparam int OW = 192;
    localparam int DEPTH = 1024;
    localparam int AW = 10;
    localparam int DW = 6;
    localparam int BEATS = (OW + IW - 1) / IW;

    logic          clk, rst, wr, rd, flush, clr_err;
    logic [IW-1:0] data_in;
    logic [DW-1:0] rd_div;
    logic [AW:0]   thresh;
    logic [OW-1:0] data_out;
    logic          rd_valid, full, empty, threshold, overflow, underflow;
    logic [AW:0]   data_count;

    datapath_gearbox_fifo #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .ADDR_W(AW), .DIV_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd), .rd_div(rd_div),
        .thresh(thresh), .flush(flush), .clr_err(clr_err), .data_out(data_out),
        .rd_valid(rd_valid), .data_count(data_count), .full(full), .empty(empty),
        .threshold(threshold), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 0;

    // Reference model state
    logic [OW-1:0] m_q[$];
    logic [OW-1:0] exp_q[$];
    logic [IW-1:0] m_beats[8];
    int            m_beat, m_div;
    logic [OW-1:0] m_dout;
    bit            m_rv, m_ov, m_un;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void fail_now(string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s", nm);
    endfunction

    task automatic model_update();
        bit slot, emp, ful, pop, fin, acc;
        logic [8*IW-1:0] wide;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_beat = 0; m_div = 0; m_dout = '0; m_rv = 0; m_ov = 0; m_un = 0;
        end else begin
            slot = (m_div == int'(rd_div));
            emp  = (m_q.size() == 0);
            ful  = (m_q.size() == DEPTH);
            pop  = rd && slot && !emp;
            fin  = wr && (m_beat == BEATS - 1);
            acc  = !ful || pop;
            wide = 0;
            wide[IW-1:0] = data_in;
            for (int k = BEATS - 2; k >= 0; k--) wide = (wide << IW) | m_beats[k];
            m_ov = (fin && !acc) || (m_ov && !clr_err);
            m_un = (rd && slot && emp) || (m_un && !clr_err);
            m_rv = 0;
            if (flush) begin
                m_q.delete();
                m_beat = 0;
            end else begin
                if (pop) begin
                    m_dout = m_q.pop_front();
                    m_rv = 1;
                    exp_q.push_back(m_dout);
                end
                if (fin && acc) m_q.push_back(wide[OW-1:0]);
                if (wr) begin
                    if (fin) m_beat = 0;
                    else begin
                        m_beats[m_beat] = data_in;
                        m_beat++;
                    end
                end
            end
            m_div = (slot || m_div > int'(rd_div)) ? 0 : m_div + 1;
        end
    endtask

    // Scoreboard monitor, sampled 2 time units after each active edge.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            chk("rd_valid", rd_valid, m_rv);
            if (rd_valid) begin
                if (exp_q.size() == 0) fail_now("unexpected_pop");
                else chk("pop_data", data_out, exp_q.pop_front());
            end
            exp_q.delete();
            chk("data_out", data_out, m_dout);
            chk("count", data_count, m_q.size());
            chk("full", full, m_q.size() == DEPTH);
            chk("empty", empty, m_q.size() == 0);
            chk("threshold", threshold, m_q.size() >= int'(thresh));
            chk("overflow", overflow, m_ov);
            chk("underflow", underflow, m_un);
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
        end
    endtask

    task automatic put_word(logic [IW-1:0] b0, logic [IW-1:0] b1);
        wr = 1; data_in = b0; step();
        data_in = b1; step();
        wr = 0;
    endtask

    task automatic wait_valid(int budget, string nm);
        for (int i = 0; i < budget && !rd_valid; i++) step();
        if (!rd_valid) fail_now({nm, "_timeout"});
    endtask

    function automatic logic [IW-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [IW-1:0] a, b, c, d, w0a, w0b, lb0, lb1;
    int pulses, last_cyc, cyc;

    initial begin
        rst = 1; wr = 0; rd = 0; flush = 0; clr_err = 0; data_in = '0; rd_div = '0;
        thresh = '0;
        @(negedge clk);
        step(2);
        mon_en = 1;
        rst = 0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_threshold", threshold, 1);

        // 1: basic pack and pop
        a = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        b = {64'h5555_AAAA_5555_AAAA, 64'hCAFE_F00D_DEAD_BEEF};
        rd = 1;
        put_word(a, b);
        wait_valid(5, "t1");
        chk("t1_data", data_out, {64'hCAFE_F00D_DEAD_BEEF, a});
        rd = 0; clr_err = 1; step(); clr_err = 0;

        // 2: paced reads, then underflow
        for (int i = 0; i < 5; i++) begin
            lb0 = rnd_beat(); lb1 = rnd_beat();
            put_word(lb0, lb1);
        end
        rd_div = 6'd29; rd = 1;
        pulses = 0; last_cyc = 0;
        for (cyc = 0; cyc < 200; cyc++) begin
            step();
            if (rd_valid) begin
                if (pulses > 0) chk("t2_spacing", cyc - last_cyc, 30);
                pulses++;
                last_cyc = cyc;
            end
        end
        chk("t2_pulses", pulses, 5);
        chk("t2_underflow", underflow, 1);
        chk("t2_last_data", data_out, {lb1[63:0], lb0});
        rd = 0; rd_div = 0; clr_err = 1; step(); clr_err = 0;

        // 3: fill to full and overflow
        flush = 1; step(); flush = 0;
        w0a = rnd_beat(); w0b = rnd_beat();
        put_word(w0a, w0b);
        for (int i = 1; i < DEPTH; i++) put_word(rnd_beat(), rnd_beat());
        put_word(rnd_beat(), rnd_beat());
        chk("t3_count", data_count, DEPTH);
        chk("t3_full", full, 1);
        chk("t3_overflow", overflow, 1);
        clr_err = 1; step(); clr_err = 0;

        // 4: commit and pop together while full
        wr = 1; data_in = rnd_beat(); step();
        data_in = rnd_beat(); rd = 1; step();
        wr = 0; rd = 0;
        chk("t4_count", data_count, DEPTH);
        chk("t4_overflow", overflow, 0);
        chk("t4_word0", data_out, {w0b[63:0], w0a});
        rd = 1;
        for (int i = 0; i < 3000; i++) put_word(rnd_beat(), rnd_beat());
        step(1100);
        chk("t4_drained", empty, 1);
        rd = 0; flush = 1; clr_err = 1; step(); flush = 0; clr_err = 0;

        // 5: threshold crossing
        thresh = 11'd512;
        for (int i = 0; i < 511; i++) put_word(rnd_beat(), rnd_beat());
        chk("t5_511", threshold, 0);
        put_word(rnd_beat(), rnd_beat());
        chk("t5_512", threshold, 1);
        rd = 1; step(); rd = 0;
        chk("t5_back_511", threshold, 0);
        flush = 1; step(); flush = 0;
        thresh = '0; step();
        chk("t5_thresh0", threshold, 1);

        // 6: flush mid-pack, error clear, reset mid-stream
        wr = 1; data_in = rnd_beat(); step(); wr = 0;
        flush = 1; step(); flush = 0;
        chk("t6_empty", empty, 1);
        c = rnd_beat(); d = rnd_beat();
        put_word(c, d);
        rd = 1;
        wait_valid(5, "t6");
        chk("t6_data", data_out, {d[63:0], c});
        step(2);
        chk("t6_underflow_set", underflow, 1);
        rd = 0; clr_err = 1; step(); clr_err = 0;
        chk("t6_ov_clr", overflow, 0);
        chk("t6_un_clr", underflow, 0);
        wr = 1; data_in = rnd_beat(); step();
        rst = 1; step(); rst = 0; wr = 0;
        chk("t6_rst_dout", data_out, 0);
        chk("t6_rst_count", data_count, 0);
        chk("t6_rst_valid", rd_valid, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            wr = ($urandom_range(0, 3) != 0);
            data_in = rnd_beat();
            rd = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 40) == 0) rd_div = DW'($urandom_range(0, 4));
            flush = ($urandom_range(0, 150) == 0);
            clr_err = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 200) == 0) thresh = 11'($urandom_range(0, 64));
            step();
        end
        wr = 0; rd = 0; flush = 0; clr_err = 0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
